// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for set_assoc_cache: FSM states, derived
// field widths and per-line metadata.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Tags are stored zero-extended to this width so the metadata struct stays fixed.
  localparam int TAG_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int off_w(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int block_words, input int sets);
    return addr_w - $clog2(block_words) - $clog2(sets);
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_tag_match.sv
// Parallel tag compare across one set: reports the hit way and the lowest
// numbered invalid way.
module cache_tag_match
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  line_meta_t [WAYS-1:0] meta_i,
  input  logic [TAG_MAX_W-1:0]  tag_i,
  output logic                  hit_o,
  output logic [WAY_W-1:0]      hit_way_o,
  output logic                  inv_found_o,
  output logic [WAY_W-1:0]      inv_way_o
);

  // Scan from the top so the lowest-numbered way is the last one written.
  always_comb begin
    hit_o       = 1'b0;
    hit_way_o   = '0;
    inv_found_o = 1'b0;
    inv_way_o   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (meta_i[w].valid && (meta_i[w].tag == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
      if (!meta_i[w].valid) begin
        inv_found_o = 1'b1;
        inv_way_o   = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Read-only N-way set-associative cache with block fills, round-robin victims
// and bulk flush. Define CACHE_STATS_EN to enable the hit/miss counters.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 64,
  parameter int WAYS        = 2
) (
  input  logic                          clock,
  input  logic                          rstN,
  input  logic                          reqValid,
  input  logic [ADDR_W-1:0]             reqAddr,
  output logic                          reqReady,
  output logic                          respValid,
  output logic [WORD_W-1:0]             respData,
  output logic                          Hit,
  output logic                          Miss,
  input  logic                          flush,
  output logic                          memReq,
  output logic [ADDR_W-1:0]             memAddr,
  input  logic                          memValid,
  input  logic [BLOCK_WORDS*WORD_W-1:0] memData,
  output logic [31:0]                   hitCount,
  output logic [31:0]                   missCount,
  output logic [1:0]                    dbgState
);

  localparam int OFF_W = off_w(BLOCK_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int WAY_W = way_w(WAYS);

  // Handshake: a request transfers on an edge where reqValid & reqReady; a
  // fill transfers on an edge where memReq & memValid; respValid is a pulse.
  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    hit_q, hit_d;
  logic                    miss_q, miss_d;
  logic [WORD_W-1:0]       resp_data_q, resp_data_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    do_flush, do_fill;

  line_meta_t [WAYS-1:0]   meta_q [SETS];
  logic [WAY_W-1:0]        ptr_q  [SETS];
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] data_q [SETS][WAYS];

  logic [ADDR_W-1:0]       lk_addr;
  logic [OFF_W-1:0]        lk_off;
  logic [IDX_W-1:0]        lk_idx;
  logic [TAG_MAX_W-1:0]    lk_tag;
  logic                    lk_hit, lk_inv_found;
  logic [WAY_W-1:0]        lk_hit_way, lk_inv_way, victim, ptr_nxt;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] fill_blk;

  // Lookup uses the live request in IDLE and the latched miss address otherwise.
  assign lk_addr  = (state_q == ST_IDLE) ? reqAddr : addr_q;
  assign lk_off   = lk_addr[OFF_W-1:0];
  assign lk_idx   = lk_addr[OFF_W +: IDX_W];
  assign lk_tag   = TAG_MAX_W'(lk_addr[ADDR_W-1:OFF_W+IDX_W]);
  assign fill_blk = memData;

  cache_tag_match #(.WAYS(WAYS), .WAY_W(WAY_W)) u_match (
    .meta_i      (meta_q[lk_idx]),
    .tag_i       (lk_tag),
    .hit_o       (lk_hit),
    .hit_way_o   (lk_hit_way),
    .inv_found_o (lk_inv_found),
    .inv_way_o   (lk_inv_way)
  );

  assign ptr_nxt = (ptr_q[lk_idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[lk_idx] + 1'b1;
  assign victim  = lk_inv_found ? lk_inv_way : ptr_q[lk_idx];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    resp_data_d  = resp_data_q;
    flush_pend_d = flush_pend_q;
    do_flush     = 1'b0;
    do_fill      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush || flush_pend_q) begin
          do_flush     = 1'b1;
          flush_pend_d = 1'b0;
        end else if (reqValid) begin
          if (lk_hit) begin
            resp_valid_d = 1'b1;
            hit_d        = 1'b1;
            resp_data_d  = data_q[lk_idx][lk_hit_way][lk_off];
          end else begin
            addr_d  = reqAddr;
            miss_d  = 1'b1;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (memValid) begin
          do_fill      = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = fill_blk[lk_off];
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush) flush_pend_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      resp_data_q  <= '0;
      flush_pend_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        meta_q[s] <= '0;
        ptr_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      resp_data_q  <= resp_data_d;
      flush_pend_q <= flush_pend_d;
      if (do_flush) begin
        for (int s = 0; s < SETS; s++) begin
          meta_q[s] <= '0;
          ptr_q[s]  <= '0;
        end
      end else if (do_fill) begin
        meta_q[lk_idx][victim] <= '{valid: 1'b1, tag: lk_tag};
        if (!lk_inv_found) ptr_q[lk_idx] <= ptr_nxt;
      end
    end
  end

  // Block data needs no reset: valid bits gate every read.
  always_ff @(posedge clock) begin
    if (do_fill) data_q[lk_idx][victim] <= fill_blk;
  end

  assign reqReady  = (state_q == ST_IDLE) && !flush && !flush_pend_q;
  assign respValid = resp_valid_q;
  assign respData  = resp_data_q;
  assign Hit       = hit_q;
  assign Miss      = miss_q;
  assign memReq    = (state_q == ST_FILL);
  assign memAddr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dbgState  = state_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_q)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_q) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`else
  assign hitCount  = '0;
  assign missCount = '0;
`endif

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised, read-only, N-way set-associative cache between the processor's load path and `dataMemory`. It generalises the direct-mapped block cache in four ways:
- configurable geometry;
- valid/ready handshakes on both sides;
- multi-cycle memory fills;
- round-robin replacement and a bulk flush.

Hits return in one cycle. Misses fetch a whole block from memory, install it, then return the requested word.

## Interface
Parameters:
- `ADDR_W`, 15, word address width
- `WORD_W`, 32, data word width
- `BLOCK_WORDS`, 4, words per block, power of 2
- `SETS`, 64, number of sets, power of 2
- `WAYS`, 2, associativity, power of 2, ≥1

Ports:
- `clock` in 1: single clock, rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `reqValid` in 1: read request.
- `reqAddr` in ADDR_W: word address.
- `reqReady` out 1: request accepted when `reqValid & reqReady`.
- `respValid` out 1: one-cycle pulse; `respData` valid.
- `respData` out WORD_W: returned word.
- `Hit` out 1: one-cycle pulse, coincident with a hit response.
- `Miss` out 1: one-cycle pulse, the cycle after a missing request is accepted.
- `flush` in 1: invalidate all lines.
- `memReq` out 1: block fetch request, held until `memValid`.
- `memAddr` out ADDR_W: block-aligned address, with the offset bits at 0.
- `memValid` in 1: fill data valid, sampled only while `memReq` is high.
- `memData` in BLOCK_WORDS*WORD_W: block data; word 0 is in the LSBs.
- `hitCount`, `missCount` out 32: statistics (see Configuration).

## Operation
- Address split, LSB first:
  - offset = log2(BLOCK_WORDS) bits;
  - index = log2(SETS) bits;
  - tag = the remaining bits.
- Per line: valid bit, tag and data. Per set: victim pointer of log2(WAYS) bits.
- FSM states: IDLE, FILL, RESP.
- IDLE:
  - `reqReady` = `!flush & !flushPending`.
  - Lookup compares all ways combinationally.
  - Hit: next cycle `respValid`=1, `Hit`=1, `respData` = hit word. FSM stays in IDLE, so back-to-back hits run at 1 per cycle.
  - Miss: latch the address. Next cycle `Miss`=1, `memReq`=1, FSM goes to FILL.
- FILL:
  - `memReq` held high and `memAddr` held stable until `memValid`.
  - On `memValid`:
    - Victim is the lowest-numbered invalid way. If every way is valid, the victim is the set's victim pointer, and the pointer increments mod WAYS.
    - Write data, tag and valid=1.
    - Register the requested word. Go to RESP.
- RESP: `respValid`=1 (with `Hit`=0), then return to IDLE.
- Flush:
  - In IDLE, `flush` clears every valid bit and every victim pointer at the next edge.
  - If `flush` is asserted in FILL or RESP, it sets `flushPending`. The flush runs on the first IDLE cycle; the fill in progress still completes its response first.
- Reset, including mid-FILL:
  - All valid bits, victim pointers, `flushPending` and counters cleared.
  - FSM returns to IDLE.
  - A late `memValid` arriving after reset is ignored.
- Output reset values: `reqReady`=1, all other outputs 0.

## Timing
- Hit latency: request accepted at edge N → `respValid` high during cycle N+1.
- Miss timing:
  - `Miss` and `memReq` rise in cycle N+1.
  - If `memValid` is sampled at edge M (M ≥ N+1), `respValid` is high during cycle M+1.
  - With a combinational memory, total miss latency is 2 cycles.
- `reqReady` is 0 in FILL and RESP; there is no hit-under-miss.
- Responses are returned in request order.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hitCount` increments on each `Hit` pulse; `missCount` increments on each `Miss` pulse.
  - Both wrap at 2^32 and are cleared by reset only; flush does not clear them.
- Not defined: both counters are tied to 0 and no counter registers are inferred.

## Structure
- Package `cache_pkg`:
  - FSM state enum;
  - derived-width localparam functions for offset, index and tag;
  - line-metadata struct (valid, tag).
- Sub-module `cache_tag_match`: one set's tags and valid bits plus the lookup tag in; hit, hit-way index and first-invalid way out.

## Test plan
Defaults throughout: SETS=64, WAYS=2, BLOCK_WORDS=4.
1. Cold read of 185, with memory returning block 46 = {0xA0, 0xA1, 0xA2, 0xA3} after 3 cycles → `Miss` at N+1, `memAddr`=184, `respData`=0xA1; then reading 187 → `Hit` next cycle, `respData`=0xA3.
2. Reads of 185, 441, 697 (same set 46, tags 0, 1, 2) → three misses. 697 evicts way 0 (185); re-reading 441 hits, re-reading 185 misses.
3. Back-to-back hits on 185, 186, 184 in consecutive cycles → three consecutive `respValid`/`Hit` pulses, with `reqReady` held at 1.
4. Assert `flush` during FILL for 189 → response for 189 is still delivered; the flush takes effect in the next IDLE cycle; a following read of 189 misses.
5. Drop `rstN` while `memReq`=1, then pulse `memValid` → no `respValid`; all outputs at reset values; a subsequent read of 185 misses.
6. With `CACHE_STATS_EN`, run scenario 2 followed by the 441 re-read → `hitCount`=1, `missCount`=3.
